// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI peripheral: state encodings,
// default geometry and the byte counter ceiling.
package spi_pkg;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    localparam logic [7:0] BYTE_COUNT_MAX = 8'd255;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a history
// flop that turns the synchronized level into rise/fall strobes.
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
)(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            hist  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            hist  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/spi_sync_peripheral.sv
// SPI mode-0 peripheral oversampled in the usb_clk domain: receives MSB-first
// words on PICO, shifts response words out on POCI, strobes results downstream.
module spi_sync_peripheral
    import spi_pkg::*;
#(
    parameter int pDATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int pSYNC_STAGES = DEFAULT_SYNC_STAGES
)(
    input  logic                   usb_clk,
    input  logic                   rst,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    input  logic                   spi_pico,
    output logic                   spi_poci,
    output logic [pDATA_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_abort,
    input  logic [pDATA_WIDTH-1:0] tx_data,
    output logic                   tx_load,
    output logic                   busy,
    output logic [7:0]             byte_count
);

    localparam int CNT_W    = $clog2(pDATA_WIDTH + 1);
    localparam int SETTLE   = pSYNC_STAGES + 1;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level;
    logic pico_level, pico_rise_unused, pico_fall_unused;

    spi_pin_sync #(.STAGES(pSYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(usb_clk), .rst(rst), .pin(spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.STAGES(pSYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(usb_clk), .rst(rst), .pin(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.STAGES(pSYNC_STAGES), .RESET_VAL(1'b0)) u_pico_sync (
        .clk(usb_clk), .rst(rst), .pin(spi_pico),
        .level(pico_level), .rise(pico_rise_unused), .fall(pico_fall_unused)
    );

    spi_state_t             state, state_nxt;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic [pDATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
    logic [pDATA_WIDTH-1:0] tx_shift, tx_shift_nxt;
    logic [pDATA_WIDTH-1:0] rx_data_nxt;
    logic [7:0]             byte_count_nxt;
    logic                   reload, reload_nxt;
    logic                   poci_nxt, rx_valid_nxt, rx_abort_nxt, tx_load_nxt;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   armed;

    // A frame may only start once CS_N has been seen high through a flushed
    // synchronizer, so a CS_N held low across reset cannot fake a falling edge.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (settle_cnt != SETTLE_W'(SETTLE)) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
        end else if (cs_level) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            state      <= SPI_IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            reload     <= 1'b0;
            spi_poci   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_abort   <= 1'b0;
            tx_load    <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            rx_shift   <= rx_shift_nxt;
            tx_shift   <= tx_shift_nxt;
            reload     <= reload_nxt;
            spi_poci   <= poci_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            rx_abort   <= rx_abort_nxt;
            tx_load    <= tx_load_nxt;
            byte_count <= byte_count_nxt;
        end
    end

    // CS_N deassertion is tested first so it overrides a coincident SCLK edge.
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        rx_shift_nxt   = rx_shift;
        tx_shift_nxt   = tx_shift;
        reload_nxt     = reload;
        poci_nxt       = spi_poci;
        rx_data_nxt    = rx_data;
        byte_count_nxt = byte_count;
        rx_valid_nxt   = 1'b0;
        rx_abort_nxt   = 1'b0;
        tx_load_nxt    = 1'b0;

        case (state)
            SPI_IDLE: begin
                if (cs_fall && armed) begin
                    state_nxt      = SPI_ACTIVE;
                    bit_cnt_nxt    = '0;
                    byte_count_nxt = '0;
                    reload_nxt     = 1'b0;
                    tx_shift_nxt   = tx_data;
                    tx_load_nxt    = 1'b1;
                    poci_nxt       = tx_data[pDATA_WIDTH-1];
                end
            end
            SPI_ACTIVE: begin
                if (cs_rise) begin
                    state_nxt    = SPI_IDLE;
                    rx_abort_nxt = (bit_cnt != '0);
                    bit_cnt_nxt  = '0;
                    reload_nxt   = 1'b0;
                    poci_nxt     = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_nxt = {rx_shift[pDATA_WIDTH-2:0], pico_level};
                    if (bit_cnt == CNT_W'(pDATA_WIDTH - 1)) begin
                        bit_cnt_nxt  = '0;
                        rx_data_nxt  = rx_shift_nxt;
                        rx_valid_nxt = 1'b1;
                        reload_nxt   = 1'b1;
                        if (byte_count != BYTE_COUNT_MAX)
                            byte_count_nxt = byte_count + 8'd1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload) begin
                        tx_shift_nxt = tx_data;
                        tx_load_nxt  = 1'b1;
                        reload_nxt   = 1'b0;
                    end else begin
                        tx_shift_nxt = tx_shift << 1;
                    end
                    poci_nxt = tx_shift_nxt[pDATA_WIDTH-1];
                end
            end
        endcase
    end

    assign busy = (state == SPI_ACTIVE);

endmodule

// File: tb/tb_spi_sync_peripheral.sv
// Directed bench for spi_sync_peripheral: table of single-word frames plus
// hand-written sequences for multi-word, abort and reset corner cases.
module tb_spi_sync_peripheral;

    localparam int HALF = 6;

    logic       usb_clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_cs_n, spi_pico;
    logic       spi_poci;
    logic [7:0] rx_data;
    logic       rx_valid, rx_abort;
    logic [7:0] tx_data;
    logic       tx_load, busy;
    logic [7:0] byte_count;

    spi_sync_peripheral #(.pDATA_WIDTH(8), .pSYNC_STAGES(2)) dut (
        .usb_clk(usb_clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_pico(spi_pico),
        .spi_poci(spi_poci),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_abort(rx_abort),
        .tx_data(tx_data), .tx_load(tx_load),
        .busy(busy), .byte_count(byte_count)
    );

    always #5 usb_clk = ~usb_clk;

    int total = 0;
    int bad   = 0;

    // Strobe counters count high cycles, so a stretched pulse shows up too.
    int n_valid = 0, n_abort = 0, n_load = 0, n_overlap = 0;
    always @(negedge usb_clk) begin
        if (!rst) begin
            if (rx_valid)             n_valid   <= n_valid + 1;
            if (rx_abort)             n_abort   <= n_abort + 1;
            if (tx_load)              n_load    <= n_load + 1;
            if (rx_valid && rx_abort) n_overlap <= n_overlap + 1;
        end
    end

    typedef struct {
        logic [7:0] pico_word;
        logic [7:0] tx_word;
        logic [7:0] exp_rx;
        logic [7:0] exp_poci;
    } vec_t;

    vec_t vecs[4];
    int   b_valid, b_abort, b_load;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

    task automatic snapshot();
        b_valid = n_valid;
        b_abort = n_abort;
        b_load  = n_load;
    endtask

    // Host side of nbits SCLK periods; POCI is read just before each rise.
    task automatic apply_stimulus(input logic [7:0] w, input int nbits, output logic [7:0] poci_word);
        poci_word = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_pico = w[7-i];
            wait_cycles(HALF);
            poci_word[7-i] = spi_poci;
            spi_sclk = 1'b1;
            wait_cycles(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    logic [7:0] pw;

    initial begin
        vecs[0] = '{pico_word: 8'hA5, tx_word: 8'h3C, exp_rx: 8'hA5, exp_poci: 8'h3C};
        vecs[1] = '{pico_word: 8'h00, tx_word: 8'hFF, exp_rx: 8'h00, exp_poci: 8'hFF};
        vecs[2] = '{pico_word: 8'hFF, tx_word: 8'h00, exp_rx: 8'hFF, exp_poci: 8'h00};
        vecs[3] = '{pico_word: 8'h5A, tx_word: 8'h81, exp_rx: 8'h5A, exp_poci: 8'h81};

        rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_pico = 1'b0; tx_data = 8'h00;
        wait_cycles(3);
        check_output("reset poci",       32'(spi_poci),   0);
        check_output("reset rx_valid",   32'(rx_valid),   0);
        check_output("reset rx_abort",   32'(rx_abort),   0);
        check_output("reset tx_load",    32'(tx_load),    0);
        check_output("reset busy",       32'(busy),       0);
        check_output("reset rx_data",    32'(rx_data),    0);
        check_output("reset byte_count", 32'(byte_count), 0);
        rst = 1'b0;
        wait_cycles(6);
        check_output("post-reset busy",    32'(busy),       0);
        check_output("post-reset poci",    32'(spi_poci),   0);
        check_output("post-reset rx_data", 32'(rx_data),    0);
        check_output("post-reset count",   32'(byte_count), 0);

        for (int v = 0; v < 4; v++) begin
            snapshot();
            tx_data  = vecs[v].tx_word;
            spi_cs_n = 1'b0;
            wait_cycles(HALF);
            check_output("vec tx_load at start", 32'(n_load - b_load), 1);
            check_output("vec busy in frame",    32'(busy), 1);
            apply_stimulus(vecs[v].pico_word, 8, pw);
            wait_cycles(HALF);
            check_output("vec rx_valid pulses", 32'(n_valid - b_valid), 1);
            check_output("vec rx_data",         32'(rx_data), 32'(vecs[v].exp_rx));
            check_output("vec poci word",       32'(pw), 32'(vecs[v].exp_poci));
            check_output("vec byte_count",      32'(byte_count), 1);
            spi_cs_n = 1'b1;
            wait_cycles(HALF);
            check_output("vec busy after",  32'(busy), 0);
            check_output("vec no abort",    32'(n_abort - b_abort), 0);
            check_output("vec poci idle",   32'(spi_poci), 0);
        end

        // Two words in one frame, response word changed after the first load.
        snapshot();
        tx_data  = 8'hA0;
        spi_cs_n = 1'b0;
        wait_cycles(HALF);
        tx_data = 8'hC3;
        apply_stimulus(8'h11, 8, pw);
        check_output("b2b word1 poci",     32'(pw), 'hA0);
        check_output("b2b word1 rx_data",  32'(rx_data), 'h11);
        check_output("b2b loads before 8th fall", 32'(n_load - b_load), 1);
        wait_cycles(HALF);
        check_output("b2b loads after 8th fall",  32'(n_load - b_load), 2);
        apply_stimulus(8'h12, 8, pw);
        wait_cycles(HALF);
        check_output("b2b word2 poci",     32'(pw), 'hC3);
        check_output("b2b word2 rx_data",  32'(rx_data), 'h12);
        check_output("b2b rx_valid pulses", 32'(n_valid - b_valid), 2);
        check_output("b2b byte_count",     32'(byte_count), 2);
        spi_cs_n = 1'b1;
        wait_cycles(HALF);
        check_output("b2b no abort", 32'(n_abort - b_abort), 0);

        // Abort after five bits.
        snapshot();
        spi_cs_n = 1'b0;
        wait_cycles(HALF);
        apply_stimulus(8'hF0, 5, pw);
        wait_cycles(HALF);
        spi_cs_n = 1'b1;
        wait_cycles(HALF);
        check_output("abort pulses",   32'(n_abort - b_abort), 1);
        check_output("abort no valid", 32'(n_valid - b_valid), 0);
        check_output("abort rx_data",  32'(rx_data), 'h12);
        check_output("abort busy",     32'(busy), 0);

        // Reset mid-word, released with CS_N still low.
        spi_cs_n = 1'b0;
        wait_cycles(HALF);
        apply_stimulus(8'hE0, 3, pw);
        rst = 1'b1;
        wait_cycles(2);
        check_output("midreset busy",    32'(busy), 0);
        check_output("midreset rx_data", 32'(rx_data), 0);
        rst = 1'b0;
        snapshot();
        apply_stimulus(8'hFF, 8, pw);
        wait_cycles(HALF);
        check_output("held-low no valid", 32'(n_valid - b_valid), 0);
        check_output("held-low no load",  32'(n_load - b_load), 0);
        check_output("held-low busy",     32'(busy), 0);
        spi_cs_n = 1'b1;
        wait_cycles(HALF);
        spi_cs_n = 1'b0;
        wait_cycles(HALF);
        check_output("rearm busy", 32'(busy), 1);
        apply_stimulus(8'h96, 8, pw);
        wait_cycles(HALF);
        check_output("rearm rx_valid", 32'(n_valid - b_valid), 1);
        check_output("rearm rx_data",  32'(rx_data), 'h96);
        spi_cs_n = 1'b1;
        wait_cycles(HALF);

        // CS_N rise coincident with the 8th SCLK rise.
        snapshot();
        spi_cs_n = 1'b0;
        wait_cycles(HALF);
        apply_stimulus(8'h55, 7, pw);
        spi_pico = 1'b1;
        wait_cycles(HALF);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        wait_cycles(HALF);
        spi_sclk = 1'b0;
        wait_cycles(HALF);
        check_output("coincident abort",    32'(n_abort - b_abort), 1);
        check_output("coincident no valid", 32'(n_valid - b_valid), 0);
        check_output("coincident rx_data",  32'(rx_data), 'h96);
        check_output("coincident busy",     32'(busy), 0);

        check_output("valid/abort overlap", 32'(n_overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_sync_peripheral.md
# spi_sync_peripheral

Synchronous SPI mode-0 peripheral for the CW305 target's bit-banged SPI link. The host drives SCLK, CS_N and PICO through USB address lines. This block oversamples those asynchronous pins in the `usb_clk` domain, assembles MSB-first bytes, and shifts a response byte out on POCI. It replaces direct pin-clocked shift registers and feeds received bytes to the downstream command/LED decode logic as single-cycle strobes.

## Interface
Parameters:
- `pDATA_WIDTH`, 8: bits per SPI word; all data ports use this width.
- `pSYNC_STAGES`, 2: synchronizer flops per input pin; minimum 2.

Ports:
- `usb_clk`, input, 1: sole clock; all state is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `spi_sclk`, input, 1: asynchronous SPI clock from host; idle low.
- `spi_cs_n`, input, 1: asynchronous active-low chip select.
- `spi_pico`, input, 1: asynchronous host-to-peripheral data.
- `spi_poci`, output, 1: peripheral-to-host data; registered.
- `rx_data`, output, `pDATA_WIDTH`: last complete received word; holds until the next word completes.
- `rx_valid`, output, 1: one-cycle strobe when `rx_data` updates.
- `rx_abort`, output, 1: one-cycle strobe when CS_N deasserts mid-word.
- `tx_data`, input, `pDATA_WIDTH`: next response word, sampled at each load point.
- `tx_load`, output, 1: one-cycle strobe in the cycle `tx_data` is sampled.
- `busy`, output, 1: high while a frame is active.
- `byte_count`, output, 8: words completed in the current frame; saturates at 255.

## Operation
- Each pin passes through `pSYNC_STAGES` flops plus one history flop, giving an edge detect.
  - Sync reset values: `spi_sclk` 0, `spi_cs_n` 1, `spi_pico` 0.
- States: IDLE and ACTIVE.
- IDLE → ACTIVE on a synchronized CS_N falling edge. On entry:
  - bit_cnt=0, byte_count=0.
  - tx_shift ← `tx_data`, `tx_load` pulses.
  - `spi_poci` ← `tx_data[MSB]`.
- In ACTIVE, SCLK rising edge:
  - rx_shift ← {rx_shift[W-2:0], pico_sync}; bit_cnt increments.
  - When bit_cnt reaches W, in the same update:
    - `rx_data` ← the completed word, `rx_valid` pulses.
    - byte_count increments, saturating at 255.
    - bit_cnt wraps to 0 and a reload flag is set.
- In ACTIVE, SCLK falling edge:
  - If the reload flag is set: tx_shift ← `tx_data`, `tx_load` pulses, flag clears.
  - Otherwise tx_shift shifts left.
  - In both cases `spi_poci` ← new tx_shift[MSB].
- ACTIVE → IDLE on a synchronized CS_N rising edge:
  - If bit_cnt≠0, `rx_abort` pulses and the partial word is discarded; `rx_data` is unchanged.
  - `spi_poci` ← 0 and bit_cnt ← 0.
- SCLK edges in IDLE are ignored.
- If a CS_N rising edge and an SCLK edge are detected in the same cycle, CS_N wins and the SCLK edge is ignored.
- Reset mid-frame clears all state. If CS_N is still low at reset release, no frame starts until CS_N has gone high and then low again.

## Timing
- Reset values:
  - `spi_poci`, `rx_valid`, `rx_abort`, `tx_load`, `busy`: 0.
  - `rx_data`, `byte_count`: 0.
- Pin-to-action latency is `pSYNC_STAGES`+1 `usb_clk` edges. With the default of 2, `rx_valid` is high in the cycle that begins on the 3rd edge after the edge that first samples the final SCLK rise.
- `spi_poci` updates `pSYNC_STAGES`+1 edges after each SCLK fall.
- Host must hold SCLK high and SCLK low each for at least `pSYNC_STAGES`+2 `usb_clk` periods.
- PICO must be stable from at least 1 period before the SCLK rise until `pSYNC_STAGES`+1 periods after it.
- `rx_valid`, `rx_abort` and `tx_load` are exactly one cycle wide. `rx_valid` and `rx_abort` are never high in the same cycle.
- `busy` rises and falls on the same cycles as the IDLE/ACTIVE transitions.

## Structure
- Shared package `spi_pkg`:
  - `SPI_IDLE` and `SPI_ACTIVE` state encodings.
  - Default width and sync-depth constants.
  - `BYTE_COUNT_MAX` = 255.
- One sub-module, `spi_pin_sync`: a parameterized synchronizer with rise/fall strobes and a reset value parameter. It is instantiated three times, once per input pin.

## Test plan
- Reset check: assert `rst` with CS_N high → all outputs 0, `busy`=0. Release → outputs unchanged.
- Single receive: CS_N low, shift 0xA5 MSB-first with 6-cycle half-periods → one `rx_valid` pulse, `rx_data`=0xA5, `byte_count`=1. CS_N high → `busy`=0, no `rx_abort`.
- Response: `tx_data`=0x3C at CS_N fall → `tx_load` pulses. POCI sampled at each SCLK rise reads 0,0,1,1,1,1,0,0.
- Back-to-back words: send 0x11 then 0x12 in one frame, with `tx_data` changed to 0xC3 after the first `tx_load`:
  - two `rx_valid` pulses, `rx_data` 0x11 then 0x12.
  - second `tx_load` follows the 8th SCLK fall; second POCI word reads 0xC3.
  - `byte_count`=2.
- Abort: CS_N high after 5 SCLK rises → `rx_abort` pulses once, `rx_data` keeps its prior value, no `rx_valid`.
- Corner cases:
  - Assert `rst` mid-word with CS_N low; release with CS_N still low → SCLK edges are ignored until CS_N toggles high then low.
  - CS_N rise synchronized in the same cycle as the 8th SCLK rise → `rx_abort` pulses and `rx_valid` does not.
